dct_axil_reg_slave: RTL and testbench
=====================================

// Module: dct_axil_reg_slave
// PURPOSE
//  AXI4-Lite responder that terminates the S00_AXI port of the DCT kernel IP.
//  Holds NUM_REGS software-visible 32-bit control registers and drives them to the kernel datapath.
//  Completes every transaction issued by the AXI VIP master in the block-design bench.
//  Accepts AW and W independently; allows one outstanding write and one outstanding read.
// PARAMETERS
//  DATA_WIDTH  32  AXI data width; only 32 is supported
//  ADDR_WIDTH  4   byte-address width; register index = AWADDR/ARADDR[ADDR_WIDTH-1:2]
//  NUM_REGS    4   number of implemented registers; indices >= NUM_REGS are out of range
// PORTS
//  ACLK           in   1                    clock, rising edge
//  ARESETN        in   1                    asynchronous active-low reset
//  AWADDR         in   ADDR_WIDTH           write address
//  AWPROT         in   3                    ignored
//  AWVALID/AWREADY in/out 1                 write-address handshake
//  WDATA          in   DATA_WIDTH           write data
//  WSTRB          in   DATA_WIDTH/8         byte enables
//  WVALID/WREADY  in/out 1                  write-data handshake
//  BRESP          out  2                    OKAY=2'b00, SLVERR=2'b10
//  BVALID/BREADY  out/in 1                  write-response handshake
//  ARADDR         in   ADDR_WIDTH           read address
//  ARPROT         in   3                    ignored
//  ARVALID/ARREADY in/out 1                 read-address handshake
//  RDATA          out  DATA_WIDTH           read data
//  RRESP          out  2                    read response
//  RVALID/RREADY  out/in 1                  read-data handshake
//  reg_o          out  NUM_REGS*DATA_WIDTH  register contents; reg i is at [i*32 +: 32]
//  reg_wr_o       out  NUM_REGS             one-cycle pulse: register i was written
// BEHAVIOUR
//  Reset (ARESETN=0, async):
//   - All registers, BVALID, RVALID, RDATA, BRESP, RRESP and reg_wr_o are cleared to 0.
//   - AWREADY, WREADY and ARREADY are 0.
//   - Any in-flight transaction is dropped; no response is issued for it after release.
//   - All three READY outputs go to 1 at the first edge after release.
//  Write path:
//   - AW and W are captured in separate holding flags.
//   - AWREADY=1 while no AW is held and BVALID=0. WREADY=1 while no W is held and BVALID=0.
//   - AW and W may handshake in the same cycle, or in either order any number of cycles apart.
//   - At edge E the second of the two handshakes completes.
//   - At edge E+1: the register is updated, reg_wr_o[idx] pulses high for one cycle, BVALID rises,
//     and both holding flags clear.
//   - Register update is byte-wise: byte k is updated only if WSTRB[k]=1.
//   - An in-range write with WSTRB=0 still returns OKAY and pulses reg_wr_o.
//   - Out-of-range index: no register change, no pulse, BRESP=SLVERR.
//   - BVALID and BRESP are held stable until BREADY=1; BVALID falls at that edge.
//   - AWREADY and WREADY return high in the cycle after the B handshake.
//  Read path:
//   - ARREADY=1 while RVALID=0.
//   - An AR handshake at edge E registers RDATA/RRESP and raises RVALID at E (1-cycle latency).
//   - RDATA/RRESP are held stable until RREADY=1; RVALID falls at that edge.
//   - Out-of-range index: RDATA=0, RRESP=SLVERR.
//  Simultaneous events:
//   - A read and a write to the same register in the same cycle: the read returns the pre-write value.
//   - The read and write paths never stall each other.
//  Address bits [1:0] are ignored; unaligned addresses access the containing word.
//  The write and read holding logic is a 2-flag FSM: IDLE, HAVE_AW, HAVE_W, RESP.
//   - IDLE    -> HAVE_AW on AW handshake; IDLE -> HAVE_W on W handshake.
//   - IDLE    -> RESP when AW and W handshake together.
//   - HAVE_AW -> RESP on W handshake; HAVE_W -> RESP on AW handshake.
//   - RESP    -> IDLE on B handshake.
// STRUCTURE
//  Package dct_axil_pkg holds: the resp_t enum (OKAY, SLVERR), constants REG_CTRL=0, REG_CFG=1,
//  REG_SRC=2, REG_DST=3, and the wr_state_t enum.
//  Sub-module dct_axil_reg_bank: NUM_REGS x 32 storage with byte-strobe write port and
//  combinational read port; instantiated once.
//  The AXI handshake FSMs live in this module.
// TESTING
//  - Write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 1,2,3,4; all BRESP/RRESP=OKAY;
//    reg_wr_o pulses 0001,0010,0100,1000.
//  - W valid 3 cycles before AWVALID to 0x4 with 0x55 -> WREADY low after the W handshake;
//    BVALID rises one edge after the AW handshake; reg1=0x55.
//  - reg0=0x00000001, then write 0xAABBCCDD with WSTRB=4'b0011 -> readback 0x0000CCDD.
//  - ADDR_WIDTH=5: write 0xDEAD to 0x10 -> BRESP=SLVERR, no reg_wr_o pulse;
//    read 0x10 -> RDATA=0, RRESP=SLVERR.
//  - Hold BREADY low 5 cycles after a write -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout;
//    a concurrent read of 0x8 still completes.
//  - Assert ARESETN low one cycle after the AW handshake, before W -> after release no BVALID,
//    all regs 0, READYs high at the first edge after release.

Source files
------------

// File: rtl/dct_axil_reg_slave_pkg.sv
// rtl/dct_axil_reg_slave_pkg.sv - shared types and register map for the DCT AXI4-Lite register slave
package dct_axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam int REG_CTRL = 0;
  localparam int REG_CFG  = 1;
  localparam int REG_SRC  = 2;
  localparam int REG_DST  = 3;

  typedef enum logic [1:0] {
    IDLE,
    HAVE_AW,
    HAVE_W,
    RESP
  } wr_state_t;

endpackage

// File: rtl/dct_axil_reg_slave_if.sv
// rtl/dct_axil_reg_slave_if.sv - AXI4-Lite bus bundle with master and slave views
interface dct_axil_reg_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/dct_axil_reg_slave_reg_bank.sv
// rtl/dct_axil_reg_slave_reg_bank.sv - register storage with byte-strobe write and combinational read
module dct_axil_reg_bank #(
  parameter int NUM_REGS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [NUM_REGS-1:0]            i_we,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
  input  logic [IDX_WIDTH-1:0]           i_rd_idx,
  output logic [DATA_WIDTH-1:0]          o_rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);
  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_rd_data;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (i_we[i] && i_wstrb[b]) r_mem[i][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Indices past NUM_REGS match nothing and read as zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(i_rd_idx) == i) w_rd_data = r_mem[i];
    end
  end

  assign o_rd_data = w_rd_data;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
  end
endmodule

// File: rtl/dct_axil_reg_slave.sv
// rtl/dct_axil_reg_slave.sv - AXI4-Lite register slave terminating the DCT kernel control port
module dct_axil_reg_slave
  import dct_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  dct_axil_reg_slave_if.slave            s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  output logic [NUM_REGS-1:0]            reg_wr_o
);
  localparam int IDX_W = ADDR_WIDTH - 2;

  wr_state_t               r_wr_state;
  logic [IDX_W-1:0]        r_aw_idx;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_awready, r_wready, r_bvalid;
  resp_t                   r_bresp;
  logic                    r_arready, r_rvalid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  resp_t                   r_rresp;
  logic [NUM_REGS-1:0]     r_reg_wr;

  logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [IDX_W-1:0]        w_ar_idx;
  logic [NUM_REGS-1:0]     w_wr_sel;
  logic                    w_aw_in_range, w_ar_in_range;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic                    w_unused_ok;

  assign w_aw_hs       = s_axi.AWVALID && r_awready;
  assign w_w_hs        = s_axi.WVALID && r_wready;
  assign w_ar_hs       = s_axi.ARVALID && r_arready;
  assign w_ar_idx      = s_axi.ARADDR[ADDR_WIDTH-1:2];
  assign w_aw_in_range = int'(r_aw_idx) < NUM_REGS;
  assign w_ar_in_range = int'(w_ar_idx) < NUM_REGS;
  // First cycle in RESP is the commit cycle; BVALID is still low there.
  assign w_commit      = (r_wr_state == RESP) && !r_bvalid;
  assign w_unused_ok   = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  always_comb begin
    w_wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) w_wr_sel[i] = (int'(r_aw_idx) == i);
  end

  dct_axil_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_W)
  ) u_bank (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .i_we     (w_commit ? w_wr_sel : '0),
    .i_wdata  (r_wdata),
    .i_wstrb  (r_wstrb),
    .i_rd_idx (w_ar_idx),
    .o_rd_data(w_rd_data),
    .o_regs   (reg_o)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_state <= IDLE;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= OKAY;
      r_reg_wr   <= '0;
    end else begin
      r_reg_wr <= '0;
      case (r_wr_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_aw_idx  <= s_axi.AWADDR[ADDR_WIDTH-1:2];
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata  <= s_axi.WDATA;
            r_wstrb  <= s_axi.WSTRB;
            r_wready <= 1'b0;
          end
          if (w_aw_hs && w_w_hs) r_wr_state <= RESP;
          else if (w_aw_hs)      r_wr_state <= HAVE_AW;
          else if (w_w_hs)       r_wr_state <= HAVE_W;
          else begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        HAVE_AW: if (w_w_hs) begin
          r_wdata    <= s_axi.WDATA;
          r_wstrb    <= s_axi.WSTRB;
          r_wready   <= 1'b0;
          r_wr_state <= RESP;
        end
        HAVE_W: if (w_aw_hs) begin
          r_aw_idx   <= s_axi.AWADDR[ADDR_WIDTH-1:2];
          r_awready  <= 1'b0;
          r_wr_state <= RESP;
        end
        RESP: begin
          if (!r_bvalid) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_aw_in_range ? OKAY : SLVERR;
            r_reg_wr <= w_wr_sel;
          end else if (s_axi.BREADY) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= IDLE;
          end
        end
        default: r_wr_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else if (w_ar_hs) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b1;
      r_rdata   <= w_rd_data;
      r_rresp   <= w_ar_in_range ? OKAY : SLVERR;
    end else if (r_rvalid && s_axi.RREADY) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
    end else if (!r_rvalid) begin
      r_arready <= 1'b1;
    end
  end

  assign s_axi.AWREADY = r_awready;
  assign s_axi.WREADY  = r_wready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BRESP   = r_bresp;
  assign s_axi.ARREADY = r_arready;
  assign s_axi.RVALID  = r_rvalid;
  assign s_axi.RDATA   = r_rdata;
  assign s_axi.RRESP   = r_rresp;
  assign reg_wr_o      = r_reg_wr;
endmodule

// File: tb/tb_dct_axil_reg_slave.sv
// tb/tb_dct_axil_reg_slave.sv - randomized self-checking bench for dct_axil_reg_slave
module tb_dct_axil_reg_slave;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TMO = 200;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic [NR*DW-1:0] reg_o;
  logic [NR-1:0] reg_wr_o;

  dct_axil_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  dct_axil_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(axi.slave), .reg_o(reg_o), .reg_wr_o(reg_wr_o)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  logic [NR-1:0] last_pulse;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what the bus must show, derived from the protocol rules.
  logic [31:0] m_regs [NR];
  bit          m_ready_ok, m_aw_held, m_w_held, m_pend, m_bvalid, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata, m_wdata;
  logic [3:0]  m_wstrb;
  int          m_aw_idx;
  logic [NR-1:0] m_wr;

  function automatic bit m_awready();
    return m_ready_ok && !m_aw_held && !m_bvalid;
  endfunction
  function automatic bit m_wready();
    return m_ready_ok && !m_w_held && !m_bvalid;
  endfunction
  function automatic bit m_arready();
    return m_ready_ok && !m_rvalid;
  endfunction

  task automatic model_step();
    bit aw_hs, w_hs, ar_hs, r_hs, b_hs;
    int idx;
    if (!ARESETN) begin
      for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
      m_ready_ok = 0; m_aw_held = 0; m_w_held = 0; m_pend = 0;
      m_bvalid = 0; m_rvalid = 0; m_bresp = 2'b00; m_rresp = 2'b00;
      m_rdata = 32'h0; m_wr = '0;
      return;
    end
    aw_hs = axi.AWVALID && m_awready();
    w_hs  = axi.WVALID && m_wready();
    ar_hs = axi.ARVALID && m_arready();
    r_hs  = m_rvalid && axi.RREADY;
    b_hs  = m_bvalid && axi.BREADY;
    m_wr  = '0;
    if (ar_hs) begin
      idx = int'(axi.ARADDR[AW-1:2]);
      m_rvalid = 1;
      m_rdata  = (idx < NR) ? m_regs[idx] : 32'h0;
      m_rresp  = (idx < NR) ? 2'b00 : 2'b10;
    end else if (r_hs) begin
      m_rvalid = 0;
    end
    if (m_pend) begin
      m_pend = 0; m_aw_held = 0; m_w_held = 0; m_bvalid = 1;
      if (m_aw_idx < NR) begin
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) m_regs[m_aw_idx][b*8 +: 8] = m_wdata[b*8 +: 8];
        m_wr[m_aw_idx] = 1'b1;
        m_bresp = 2'b00;
      end else begin
        m_bresp = 2'b10;
      end
    end else if (b_hs) begin
      m_bvalid = 0;
    end
    if (aw_hs) begin
      m_aw_held = 1;
      m_aw_idx  = int'(axi.AWADDR[AW-1:2]);
    end
    if (w_hs) begin
      m_w_held = 1;
      m_wdata  = axi.WDATA;
      m_wstrb  = axi.WSTRB;
    end
    if ((aw_hs || w_hs) && m_aw_held && m_w_held) m_pend = 1;
    m_ready_ok = 1;
  endtask

  initial forever begin
    @(posedge ACLK or negedge ARESETN);
    model_step();
  end

  task automatic compare();
    logic [127:0] exp_regs;
    for (int i = 0; i < NR; i++) exp_regs[i*32 +: 32] = m_regs[i];
    check("awready", 128'(axi.AWREADY), 128'(m_awready()));
    check("wready",  128'(axi.WREADY),  128'(m_wready()));
    check("arready", 128'(axi.ARREADY), 128'(m_arready()));
    check("bvalid",  128'(axi.BVALID),  128'(m_bvalid));
    check("rvalid",  128'(axi.RVALID),  128'(m_rvalid));
    check("reg_wr",  128'(reg_wr_o),    128'(m_wr));
    check("reg_o",   128'(reg_o),       exp_regs);
    if (m_bvalid) check("bresp", 128'(axi.BRESP), 128'(m_bresp));
    if (m_rvalid) begin
      check("rdata", 128'(axi.RDATA), 128'(m_rdata));
      check("rresp", 128'(axi.RRESP), 128'(m_rresp));
    end
    if (!ARESETN) begin
      check("rst_rdata", 128'(axi.RDATA), 128'(0));
      check("rst_bresp", 128'(axi.BRESP), 128'(0));
    end
  endtask

  initial forever begin
    @(negedge ACLK);
    if (chk_on) compare();
    if (reg_wr_o != '0) last_pulse = reg_wr_o;
  end

  task automatic drive_aw(input logic [AW-1:0] a, input int dly);
    int n = 0;
    repeat (dly) @(negedge ACLK);
    axi.AWADDR = a; axi.AWPROT = 3'($urandom_range(0, 7)); axi.AWVALID = 1'b1;
    while (axi.AWREADY !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
    check("aw_timeout", 128'(n < TMO), 128'(1));
    @(negedge ACLK);
    axi.AWVALID = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n = 0;
    repeat (dly) @(negedge ACLK);
    axi.WDATA = d; axi.WSTRB = s; axi.WVALID = 1'b1;
    while (axi.WREADY !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
    check("w_timeout", 128'(n < TMO), 128'(1));
    @(negedge ACLK);
    axi.WVALID = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp);
    int n = 0;
    fork
      drive_aw(a, aw_dly);
      drive_w(d, s, w_dly);
    join
    while (axi.BVALID !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
    check("b_timeout", 128'(n < TMO), 128'(1));
    resp = axi.BRESP;
    repeat (b_dly) @(negedge ACLK);
    axi.BREADY = 1'b1;
    @(negedge ACLK);
    axi.BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly,
                         output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    repeat (ar_dly) @(negedge ACLK);
    axi.ARADDR = a; axi.ARPROT = 3'($urandom_range(0, 7)); axi.ARVALID = 1'b1;
    while (axi.ARREADY !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
    check("ar_timeout", 128'(n < TMO), 128'(1));
    @(negedge ACLK);
    axi.ARVALID = 1'b0;
    n = 0;
    while (axi.RVALID !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
    check("r_timeout", 128'(n < TMO), 128'(1));
    d = axi.RDATA; resp = axi.RRESP;
    repeat (r_dly) @(negedge ACLK);
    axi.RREADY = 1'b1;
    @(negedge ACLK);
    axi.RREADY = 1'b0;
  endtask

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd;
    logic [AW-1:0] ra;
    axi.AWADDR = '0; axi.AWPROT = '0; axi.AWVALID = 0;
    axi.WDATA = '0; axi.WSTRB = '0; axi.WVALID = 0; axi.BREADY = 0;
    axi.ARADDR = '0; axi.ARPROT = '0; axi.ARVALID = 0; axi.RREADY = 0;
    last_pulse = '0;
    ARESETN = 1'b1;
    #1 ARESETN = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge ACLK);
    #2 ARESETN = 1'b1;
    @(negedge ACLK);
    check("reset_regs", 128'(reg_o), 128'(0));
    check("reset_readies", 128'({axi.AWREADY, axi.WREADY, axi.ARREADY}), 128'(3'b111));

    for (int i = 0; i < 4; i++) begin
      last_pulse = '0;
      do_write(AW'(i*4), 32'(i+1), 4'hF, 0, 0, 0, br);
      check("seq_bresp", 128'(br), 128'(0));
      check("seq_pulse", 128'(last_pulse), 128'(4'b0001 << i));
    end
    for (int i = 0; i < 4; i++) begin
      do_read(AW'(i*4), 0, 0, rd, rr);
      check("seq_rdata", 128'(rd), 128'(i+1));
      check("seq_rresp", 128'(rr), 128'(0));
    end

    do_write(5'h04, 32'h55, 4'hF, 3, 0, 0, br);
    check("wfirst_reg1", 128'(reg_o[63:32]), 128'(32'h55));

    do_write(5'h00, 32'h1, 4'hF, 0, 0, 0, br);
    do_write(5'h00, 32'hAABBCCDD, 4'b0011, 1, 0, 1, br);
    do_read(5'h00, 0, 0, rd, rr);
    check("strobe_rdata", 128'(rd), 128'(32'h0000CCDD));

    last_pulse = '0;
    do_write(5'h10, 32'hDEAD, 4'hF, 0, 0, 0, br);
    check("oor_bresp", 128'(br), 128'(2'b10));
    check("oor_pulse", 128'(last_pulse), 128'(0));
    do_read(5'h10, 0, 0, rd, rr);
    check("oor_rdata", 128'(rd), 128'(0));
    check("oor_rresp", 128'(rr), 128'(2'b10));

    fork
      do_write(5'h0C, 32'h12345678, 4'hF, 0, 0, 5, br);
      begin
        logic [31:0] d2;
        logic [1:0]  r2;
        do_read(5'h08, 2, 0, d2, r2);
        check("conc_rdata", 128'(d2), 128'(3));
        check("conc_rresp", 128'(r2), 128'(0));
      end
    join
    check("conc_bresp", 128'(br), 128'(0));

    fork
      do_write(5'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 0, br);
      begin
        logic [31:0] d3;
        logic [1:0]  r3;
        do_read(5'h0C, 1, 0, d3, r3);
        check("same_cycle_prewrite", 128'(d3), 128'(32'h12345678));
      end
    join
    do_read(5'h0D, 0, 0, rd, rr);
    check("unaligned_postwrite", 128'(rd), 128'(32'hCAFEF00D));

    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 2);
      ra = AW'($urandom_range(0, 31));
      if (op == 0) begin
        do_write(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), br);
      end else if (op == 1) begin
        do_read(ra, $urandom_range(0, 2), $urandom_range(0, 3), rd, rr);
      end else begin
        logic [AW-1:0] rb;
        rb = AW'($urandom_range(0, 31));
        fork
          do_write(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), br);
          begin
            logic [31:0] d4;
            logic [1:0]  r4;
            do_read(rb, $urandom_range(0, 3), $urandom_range(0, 3), d4, r4);
          end
        join
      end
    end

    drive_aw(5'h04, 0);
    #2 ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    #2 ARESETN = 1'b1;
    #1 check("rel_readies_low", 128'({axi.AWREADY, axi.WREADY, axi.ARREADY}), 128'(3'b000));
    @(negedge ACLK);
    check("rel_readies_high", 128'({axi.AWREADY, axi.WREADY, axi.ARREADY}), 128'(3'b111));
    for (int i = 0; i < 6; i++) begin
      check("rel_no_bvalid", 128'(axi.BVALID), 128'(0));
      check("rel_regs_zero", 128'(reg_o), 128'(0));
      @(negedge ACLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
